writeback_queue: RTL
====================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, 4, number of pending write-back entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter DATA_W, 64, register data width.
REQ-003 clk  input  1  single clock for all state; every flop rising-edge triggered.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wb_valid  input  1  producer offers a write-back entry this cycle.
REQ-006 wb_ready  output  1  queue can accept; high exactly when count < DEPTH.
REQ-007 wb_rd  input  5  destination register of offered entry.
REQ-008 wb_data  input  DATA_W  data of offered entry.
REQ-009 drain_en  input  1  permits issuing the head entry to the register file this cycle.
REQ-010 Reg_Write  output  1  register-file write enable.
REQ-011 rd  output  5  register-file write address.
REQ-012 Write_Data  output  DATA_W  register-file write data.
REQ-013 rs1, rs2  input  5 each  register-file read addresses, shared with the register file.
REQ-014 rf_Read_Data1, rf_Read_Data2  input  DATA_W each  raw register-file read data.
REQ-015 Read_Data1, Read_Data2  output  DATA_W each  read data corrected for pending writes.
REQ-016 count  output  $clog2(DEPTH)+1  number of valid entries held.

Function
REQ-017 Push SHALL occur at a rising edge where wb_valid && wb_ready; wb_rd/wb_data are stored at the tail and the tail pointer increments modulo DEPTH.
REQ-018 Push with wb_rd == 0 SHALL complete the handshake but store nothing; count unchanged.
REQ-019 Reg_Write SHALL equal (count != 0) && drain_en, combinationally from registered state and drain_en.
REQ-020 While count != 0, rd and Write_Data SHALL present the head entry; while count == 0 both SHALL be 0.
REQ-021 Pop SHALL occur at every rising edge where Reg_Write is 1; head pointer increments modulo DEPTH.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-023 When full, wb_ready SHALL be 0 even if a pop occurs in the same cycle; no same-cycle slot reuse.
REQ-024 Latency: an entry pushed into an empty queue at edge N SHALL appear on the write port in the cycle after edge N and commit at edge N+1 when drain_en is 1.
REQ-025 drain_en low SHALL hold rd/Write_Data stable on the head entry and suppress the pop.
REQ-026 count SHALL never exceed DEPTH nor underflow below 0.
REQ-027 Read_Data1/2 SHALL be 0 whenever rs1/rs2 respectively equals 0.

Reset
REQ-028 Asserting reset SHALL immediately clear count, head and tail pointers; Reg_Write, rd, Write_Data, count go 0 without waiting for clk.
REQ-029 Entries pending at reset assertion SHALL be discarded and never written.
REQ-030 wb_ready SHALL be 1 during and after reset (count == 0); pushes while reset is high are ignored.

Configuration
REQ-031 Macro WB_FORWARD_EN defined: for nonzero rs1/rs2, Read_Data1/2 SHALL return the data of the youngest valid entry whose rd matches, including the head entry being written this cycle, else rf_Read_Data1/2.
REQ-032 WB_FORWARD_EN undefined: Read_Data1/2 SHALL pass rf_Read_Data1/2 through (still 0 for x0); no match logic synthesized.

Verification
REQ-033 Empty queue, drain_en=1, push rd=3 data=64'd1 for one cycle -> next cycle Reg_Write=1, rd=3, Write_Data=1 for exactly one cycle; count 1 then 0.
REQ-034 drain_en=0, push rd=1..5 data=10..50 on 5 consecutive cycles -> 4 accepted, wb_ready=0 on 5th, count=4; then drain_en=1 -> writes rd 1,2,3,4 data 10,20,30,40 on 4 consecutive cycles.
REQ-035 drain_en=0, push rd=2 data=0xAB then rd=2 data=0xCD, rs1=2, rf_Read_Data1=0 -> Read_Data1=0xCD with WB_FORWARD_EN, 0 without; rs2=0 -> Read_Data2=0.
REQ-036 Push rd=0 data=0xFF -> handshake completes, count stays 0, Reg_Write stays 0.
REQ-037 Full queue, drain_en=1, wb_valid=1 -> wb_ready=0 that cycle, count 4 -> 3, then push accepted next cycle with count staying 3.
REQ-038 count=3, drain_en=0, assert reset mid-cycle -> Reg_Write/rd/Write_Data/count 0 before next edge; after release with drain_en=1 no write issued.

Source files
------------

// File: rtl/writeback_queue.sv
// Write-back queue between a result producer and the register file, with
// read-data correction for pending writes when WB_FORWARD_EN is defined.
module writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wb_valid,
  output logic                    wb_ready,
  input  logic [4:0]              wb_rd,
  input  logic [DATA_W-1:0]       wb_data,
  input  logic                    drain_en,
  output logic                    Reg_Write,
  output logic [4:0]              rd,
  output logic [DATA_W-1:0]       Write_Data,
  input  logic [4:0]              rs1,
  input  logic [4:0]              rs2,
  input  logic [DATA_W-1:0]       rf_Read_Data1,
  input  logic [DATA_W-1:0]       rf_Read_Data2,
  output logic [DATA_W-1:0]       Read_Data1,
  output logic [DATA_W-1:0]       Read_Data2,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [4:0]        rd_q   [DEPTH];
  logic [4:0]        rd_d   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic              push, pop, nonempty;
  logic [DATA_W-1:0] fwd1, fwd2;

  assign nonempty   = (count_q != '0);
  // No same-cycle slot reuse: a full queue refuses even when it pops.
  assign wb_ready   = (count_q != CW'(DEPTH));
  assign push       = wb_valid && wb_ready && (wb_rd != 5'd0);
  assign Reg_Write  = nonempty && drain_en;
  assign pop        = Reg_Write;
  assign rd         = nonempty ? rd_q[head_q]   : 5'd0;
  assign Write_Data = nonempty ? data_q[head_q] : '0;
  assign count      = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (push) begin
      rd_d[tail_q]   = wb_rd;
      data_d[tail_q] = wb_data;
      tail_d         = tail_q + PW'(1);
    end
    if (pop) head_d = head_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: count gates every use of it.
  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    data_q <= data_d;
  end

`ifdef WB_FORWARD_EN
  logic [PW-1:0] idx;
  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd1 = rf_Read_Data1;
    fwd2 = rf_Read_Data2;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (rd_q[idx] == rs1) fwd1 = data_q[idx];
        if (rd_q[idx] == rs2) fwd2 = data_q[idx];
      end
    end
  end
`else
  assign fwd1 = rf_Read_Data1;
  assign fwd2 = rf_Read_Data2;
`endif

  assign Read_Data1 = (rs1 == 5'd0) ? '0 : fwd1;
  assign Read_Data2 = (rs2 == 5'd0) ? '0 : fwd2;
endmodule
